// File: rtl/CPU_Defines.sv
// Shared CPU definitions: pipeline enums used across execute-stage units.
package CPU_Defines;

  // Multi-cycle divider sequencing.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } DivState_t;

  // Destination class of a register-file write.
  typedef enum logic [1:0] {
    RW_NONE = 2'd0,
    RW_GPR  = 2'd1,
    RW_HILO = 2'd2,
    RW_CP0  = 2'd3
  } RegsWrType;

endpackage

// File: rtl/exe_divider.sv
// Execute-stage DIV/DIVU unit: 32-step radix-2 restoring divider on operand
// magnitudes, with sign fix-up, divide-by-zero result and flush support.
module exe_divider
  import CPU_Defines::*;
#(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 EXE_Div_Start,
  input  logic                 EXE_Div_Signed,
  input  logic [DIV_WIDTH-1:0] EXE_Div_A,
  input  logic [DIV_WIDTH-1:0] EXE_Div_B,
  input  logic                 EXE_Flush,
  output logic                 EXE_Div_Busy,
  output logic                 EXE_Div_Done,
  output logic [DIV_WIDTH-1:0] EXE_Div_Lo,
  output logic [DIV_WIDTH-1:0] EXE_Div_Hi
);

  localparam int unsigned W         = DIV_WIDTH;
  localparam logic [5:0]  LAST_STEP = 6'(DIV_WIDTH - 1);

  DivState_t      state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   dvsr_q, dvsr_d;
  logic [W-1:0]   a_q, a_d;
  logic           signed_q, signed_d;
  logic           sign_a_q, sign_a_d;
  logic           sign_b_q, sign_b_d;
  logic           bzero_q, bzero_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [W-1:0]   hi_q, hi_d;

  logic           accept;
  logic           in_sign_a, in_sign_b;
  logic [W-1:0]   abs_a, abs_b;
  logic [W:0]     rem_sh;
  logic [W:0]     diff;
  logic           borrow;
  logic [W-1:0]   rem_step, quo_step;
  logic [W-1:0]   q_fin, r_fin;

  assign accept = (state_q == IDLE) && EXE_Div_Start && !EXE_Flush;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; flush wins over everything, including a same-cycle start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (EXE_Flush)                state_d = IDLE;
        else if (cnt_q == LAST_STEP)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state; results come from held registers.
  always_comb begin
    EXE_Div_Busy = (state_q == RUN);
    EXE_Div_Done = (state_q == DONE);
    EXE_Div_Lo   = lo_q;
    EXE_Div_Hi   = hi_q;
  end

  // Operand magnitudes and one restoring step on the current partial remainder.
  always_comb begin
    in_sign_a = EXE_Div_Signed & EXE_Div_A[W-1];
    in_sign_b = EXE_Div_Signed & EXE_Div_B[W-1];
    abs_a     = in_sign_a ? (~EXE_Div_A + 1'b1) : EXE_Div_A;
    abs_b     = in_sign_b ? (~EXE_Div_B + 1'b1) : EXE_Div_B;

    rem_sh   = {rem_q, quo_q[W-1]};
    diff     = rem_sh - {1'b0, dvsr_q};
    // A set top bit in the shifted remainder already exceeds any divisor.
    borrow   = ~rem_sh[W] & diff[W];
    rem_step = borrow ? rem_sh[W-1:0] : diff[W-1:0];
    quo_step = {quo_q[W-2:0], ~borrow};

    q_fin = (signed_q & (sign_a_q ^ sign_b_q)) ? (~quo_step + 1'b1) : quo_step;
    r_fin = (signed_q & sign_a_q)              ? (~rem_step + 1'b1) : rem_step;
    if (bzero_q) begin
      q_fin = '1;
      r_fin = a_q;
    end
  end

  // Datapath next-state: latch on accept, iterate in RUN, publish on last step.
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    a_d      = a_q;
    signed_d = signed_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    bzero_d  = bzero_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    if (accept) begin
      cnt_d    = '0;
      rem_d    = '0;
      quo_d    = abs_a;
      dvsr_d   = abs_b;
      a_d      = EXE_Div_A;
      signed_d = EXE_Div_Signed;
      sign_a_d = in_sign_a;
      sign_b_d = in_sign_b;
      bzero_d  = (EXE_Div_B == '0);
    end else if (state_q == RUN && !EXE_Flush) begin
      cnt_d = cnt_q + 6'd1;
      rem_d = rem_step;
      quo_d = quo_step;
      if (cnt_q == LAST_STEP) begin
        lo_d = q_fin;
        hi_d = r_fin;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      a_q      <= '0;
      signed_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      bzero_q  <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      a_q      <= a_d;
      signed_q <= signed_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      bzero_q  <= bzero_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

endmodule

// File: tb/tb_exe_divider.sv
// Directed self-checking bench for exe_divider.
module tb_exe_divider;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] lo;
  logic [31:0] hi;

  int pass_cnt  = 0;
  int total_cnt = 0;

  exe_divider #(.DIV_WIDTH(32)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .EXE_Div_Start (start),
    .EXE_Div_Signed(sgn),
    .EXE_Div_A     (a),
    .EXE_Div_B     (b),
    .EXE_Flush     (flush),
    .EXE_Div_Busy  (busy),
    .EXE_Div_Done  (done),
    .EXE_Div_Lo    (lo),
    .EXE_Div_Hi    (hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; on return we sample cycle 1 of the operation.
  task automatic start_div(input logic s, input logic [31:0] av, input logic [31:0] bv);
    sgn   = s;
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Step until Done is seen (bounded); n is the cycle number at which it was seen.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL reset_flags: got busy=%b done=%b, want 0 0", busy, done);
    else pass_cnt++;
    total_cnt++;
    if (lo !== 32'h0 || hi !== 32'h0) $display("FAIL reset_lohi: got lo=%h hi=%h, want 0 0", lo, hi);
    else pass_cnt++;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_unsigned_timing();
    int busy_cycles;
    logic early_done;
    busy_cycles = 0;
    early_done  = 1'b0;
    start_div(1'b0, 32'd100, 32'd7);
    for (int i = 1; i <= 32; i++) begin
      if (i > 1) tick();
      if (busy === 1'b1) busy_cycles++;
      if (done !== 1'b0) early_done = 1'b1;
    end
    total_cnt++;
    if (busy_cycles !== 32 || early_done) $display("FAIL busy_window: got busy_cycles=%0d early_done=%b, want 32 0", busy_cycles, early_done);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, done} !== 2'b01) $display("FAIL done_cycle33: got busy=%b done=%b, want 0 1", busy, done);
    else pass_cnt++;
    total_cnt++;
    if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL div_100_7: got lo=%h hi=%h, want 0000000e 00000002", lo, hi);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (done !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) $display("FAIL hold_after_done: got done=%b lo=%h hi=%h, want 0 0000000e 00000002", done, lo, hi);
    else pass_cnt++;
  endtask

  task automatic test_results();
    logic        sv [6];
    logic [31:0] av [6];
    logic [31:0] bv [6];
    logic [31:0] elo[6];
    logic [31:0] ehi[6];
    int n;
    sv[0] = 1; av[0] = 32'hFFFFFFF9; bv[0] = 32'd2;        elo[0] = 32'hFFFFFFFD; ehi[0] = 32'hFFFFFFFF;
    sv[1] = 1; av[1] = 32'd7;        bv[1] = 32'hFFFFFFFE; elo[1] = 32'hFFFFFFFD; ehi[1] = 32'd1;
    sv[2] = 0; av[2] = 32'h12345678; bv[2] = 32'd0;        elo[2] = 32'hFFFFFFFF; ehi[2] = 32'h12345678;
    sv[3] = 1; av[3] = 32'h80000000; bv[3] = 32'hFFFFFFFF; elo[3] = 32'h80000000; ehi[3] = 32'd0;
    sv[4] = 0; av[4] = 32'hFFFFFFFF; bv[4] = 32'h10;       elo[4] = 32'h0FFFFFFF; ehi[4] = 32'hF;
    sv[5] = 1; av[5] = 32'hFFFFFFF8; bv[5] = 32'hFFFFFFFD; elo[5] = 32'd2;        ehi[5] = 32'hFFFFFFFE;
    for (int i = 0; i < 6; i++) begin
      start_div(sv[i], av[i], bv[i]);
      wait_done(1, n);
      total_cnt++;
      if (n !== 33 || lo !== elo[i] || hi !== ehi[i])
        $display("FAIL result_%0d: got cycle=%0d lo=%h hi=%h, want cycle=33 lo=%h hi=%h", i, n, lo, hi, elo[i], ehi[i]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_flush_run();
    int done_seen;
    done_seen = 0;
    start_div(1'b0, 32'd100, 32'd7);
    for (int i = 2; i <= 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL flush_run: got busy=%b done=%b, want 0 0", busy, done);
    else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    total_cnt++;
    if (done_seen !== 0) $display("FAIL flush_no_done: got %0d active cycles, want 0", done_seen);
    else pass_cnt++;
  endtask

  task automatic test_flush_start();
    int active;
    active = 0;
    sgn   = 1'b0;
    a     = 32'd50;
    b     = 32'd5;
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL flush_start: got busy=%b, want 0", busy);
    else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) active++;
    end
    total_cnt++;
    if (active !== 0) $display("FAIL flush_start_idle: got %0d active cycles, want 0", active);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    int n;
    start_div(1'b0, 32'd100, 32'd7);
    for (int i = 2; i <= 5; i++) tick();
    sgn   = 1'b0;
    a     = 32'd50;
    b     = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(6, n);
    total_cnt++;
    if (n !== 33 || lo !== 32'd14 || hi !== 32'd2)
      $display("FAIL start_ignored: got cycle=%0d lo=%h hi=%h, want cycle=33 lo=0000000e hi=00000002", n, lo, hi);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_run();
    int n;
    start_div(1'b0, 32'd100, 32'd7);
    for (int i = 2; i <= 20; i++) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    total_cnt++;
    if ({busy, done} !== 2'b00 || lo !== 32'h0 || hi !== 32'h0)
      $display("FAIL reset_mid_run: got busy=%b done=%b lo=%h hi=%h, want all 0", busy, done, lo, hi);
    else pass_cnt++;
    start_div(1'b0, 32'd9, 32'd3);
    wait_done(1, n);
    total_cnt++;
    if (n !== 33 || lo !== 32'd3 || hi !== 32'd0)
      $display("FAIL after_reset_9_3: got cycle=%0d lo=%h hi=%h, want cycle=33 lo=00000003 hi=00000000", n, lo, hi);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    start_div(1'b0, 32'd1000, 32'd33);
    wait_done(1, n);
    // Flush during DONE: pulse already visible, results must survive.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total_cnt++;
    if (n !== 33 || done !== 1'b0 || lo !== 32'd30 || hi !== 32'd10)
      $display("FAIL flush_in_done: got cycle=%0d done=%b lo=%h hi=%h, want 33 0 0000001e 0000000a", n, done, lo, hi);
    else pass_cnt++;
    start_div(1'b1, 32'hFFFFFF9C, 32'd7);
    wait_done(1, n);
    total_cnt++;
    if (n !== 33 || lo !== 32'hFFFFFFF2 || hi !== 32'hFFFFFFFE)
      $display("FAIL back_to_back: got cycle=%0d lo=%h hi=%h, want 33 fffffff2 fffffffe", n, lo, hi);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    sgn    = 1'b0;
    a      = '0;
    b      = '0;
    flush  = 1'b0;
    #1;
    test_reset();
    test_unsigned_timing();
    test_results();
    test_flush_run();
    test_flush_start();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
